// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: sequence entry layout and FSM state encoding.
package tone_sequencer_pkg;

  localparam int SEQ_ENTRY_W = 24;
  localparam int STEP_MSB    = 23;
  localparam int STEP_LSB    = 8;
  localparam int DUR_MSB     = 7;
  localparam int DUR_LSB     = 0;
  localparam int STEP_W      = STEP_MSB - STEP_LSB + 1;
  localparam int DUR_W       = DUR_MSB - DUR_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic [DUR_W-1:0]  dur;
  } seq_entry_t;

  function automatic seq_entry_t unpack_entry(input logic [SEQ_ENTRY_W-1:0] word);
    seq_entry_t e;
    e.step = word[STEP_MSB:STEP_LSB];
    e.dur  = word[DUR_MSB:DUR_LSB];
    return e;
  endfunction

endpackage

// File: rtl/tone_sequencer_seq_ram.sv
// Simple dual-port sequence RAM, synchronous read with one cycle of latency, read-before-write.
module tone_sequencer_seq_ram
  import tone_sequencer_pkg::*;
#(
  parameter int SEQ_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [SEQ_ENTRY_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [SEQ_ENTRY_W-1:0] rd_data
);

  (* ram_init_file = "seqtable.mif" *)
  logic [SEQ_ENTRY_W-1:0] mem [SEQ_DEPTH];

  // NOTE: the array has no reset on purpose; the tune must survive a system reset and
  // a reset port would stop the tools mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer: walks {step, duration} entries from the sequence RAM and drives the oscillator step and gate.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int SEQ_DEPTH = 64,
  parameter int ADDR_W    = 6,
  parameter int TICK_DIV  = 48,
  parameter int GAP_UNITS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic                   tick,
  input  logic                   seq_wr_en,
  input  logic [ADDR_W-1:0]      seq_wr_addr,
  input  logic [SEQ_ENTRY_W-1:0] seq_wr_data,
  output logic [STEP_W-1:0]      step_out,
  output logic                   gate,
  output logic                   phase_clr,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      cur_addr
);

  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_TICKS = (GAP_UNITS > 0) ? GAP_UNITS * TICK_DIV : 1;
  localparam int GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam bit HAS_GAP   = (GAP_UNITS > 0);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_DEPTH - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

  seq_state_e             state_q, state_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [STEP_W-1:0]      step_d;
  logic                   gate_d, phase_clr_d, done_d;
  logic [PRE_W-1:0]       pre_cnt, pre_d;
  logic [DUR_W-1:0]       dur_cnt, dur_d;
  logic [GAP_W-1:0]       gap_cnt, gap_d;
  logic                   advance, end_of_seq;

  logic                   rd_en;
  logic [SEQ_ENTRY_W-1:0] rd_word;
  seq_entry_t             rd_entry;

  assign rd_en    = (state_q == ST_FETCH);
  assign rd_entry = unpack_entry(rd_word);
  assign busy     = (state_q != ST_IDLE);

  tone_sequencer_seq_ram #(
    .SEQ_DEPTH (SEQ_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_seq_ram (
    .clk     (clk),
    .wr_en   (seq_wr_en),
    .wr_addr (seq_wr_addr),
    .wr_data (seq_wr_data),
    .rd_en   (rd_en),
    .rd_addr (cur_addr),
    .rd_data (rd_word)
  );

  // NOTE: every signal written below gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = cur_addr;
    step_d      = step_out;
    gate_d      = gate;
    phase_clr_d = 1'b0;
    done_d      = 1'b0;
    pre_d       = pre_cnt;
    dur_d       = dur_cnt;
    gap_d       = gap_cnt;
    advance     = 1'b0;
    end_of_seq  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        if (rd_entry.dur == '0) begin
          end_of_seq = 1'b1;
        end else begin
          step_d      = rd_entry.step;
          gate_d      = (rd_entry.step != '0);
          phase_clr_d = 1'b1;
          dur_d       = rd_entry.dur;
          pre_d       = '0;
          state_d     = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          if (pre_cnt == PRE_LAST) begin
            pre_d = '0;
            dur_d = dur_cnt - 1'b1;
            // Last unit of the note: release the gate but hold the step for the envelope tail.
            if (dur_cnt == DUR_W'(1)) begin
              gate_d = 1'b0;
              if (HAS_GAP) begin
                gap_d   = '0;
                state_d = ST_GAP;
              end else begin
                advance = 1'b1;
              end
            end
          end else begin
            pre_d = pre_cnt + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            advance = 1'b1;
          end else begin
            gap_d = gap_cnt + 1'b1;
          end
        end
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (cur_addr == LAST_ADDR) begin
        end_of_seq = 1'b1;
      end else begin
        addr_d  = cur_addr + 1'b1;
        state_d = ST_FETCH;
      end
    end

    // Looping from entry 0 is refused so an empty sequence finishes instead of spinning.
    if (end_of_seq) begin
      if (loop_en && (cur_addr != '0)) begin
        addr_d  = '0;
        state_d = ST_FETCH;
      end else begin
        step_d  = '0;
        gate_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_FIN;
      end
    end

    if (stop) begin
      state_d     = ST_IDLE;
      addr_d      = '0;
      step_d      = '0;
      gate_d      = 1'b0;
      phase_clr_d = 1'b0;
      done_d      = 1'b0;
      pre_d       = '0;
      dur_d       = '0;
      gap_d       = '0;
    end
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge values
  // computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cur_addr  <= '0;
      step_out  <= '0;
      gate      <= 1'b0;
      phase_clr <= 1'b0;
      done      <= 1'b0;
      pre_cnt   <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      cur_addr  <= addr_d;
      step_out  <= step_d;
      gate      <= gate_d;
      phase_clr <= phase_clr_d;
      done      <= done_d;
      pre_cnt   <= pre_d;
      dur_cnt   <= dur_d;
      gap_cnt   <= gap_d;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a note scoreboard checked on every phase_clr pulse.
module tb_tone_sequencer;

  localparam int ADDR_W    = 6;
  localparam int SEQ_DEPTH = 64;
  localparam int TICK_DIV  = 4;
  localparam int GAP_UNITS = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start = 1'b0, stop = 1'b0, loop_en = 1'b0, tick = 1'b0;
  logic              seq_wr_en = 1'b0;
  logic [ADDR_W-1:0] seq_wr_addr = '0;
  logic [23:0]       seq_wr_data = '0;
  logic [15:0]       step_out;
  logic              gate, phase_clr, busy, done;
  logic [ADDR_W-1:0] cur_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       step;
    logic              gate;
  } note_t;

  note_t exp_q[$];

  int tick_cnt = 0, gate_tick_cnt = 0, done_cnt = 0;
  int prev_clr_tick = 0, last_clr_tick = 0, done_tick = 0;

  tone_sequencer #(
    .SEQ_DEPTH (SEQ_DEPTH),
    .ADDR_W    (ADDR_W),
    .TICK_DIV  (TICK_DIV),
    .GAP_UNITS (GAP_UNITS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .tick        (tick),
    .seq_wr_en   (seq_wr_en),
    .seq_wr_addr (seq_wr_addr),
    .seq_wr_data (seq_wr_data),
    .step_out    (step_out),
    .gate        (gate),
    .phase_clr   (phase_clr),
    .busy        (busy),
    .done        (done),
    .cur_addr    (cur_addr)
  );

  always #5 clk = ~clk;

  // Sample strobe: one cycle high out of every three.
  initial begin : tick_gen
    forever begin
      repeat (2) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every note load, plus tick/gate/done bookkeeping.
  always @(negedge clk) begin
    if (reset_n) begin
      if (phase_clr) begin
        prev_clr_tick <= last_clr_tick;
        last_clr_tick <= tick_cnt;
        check("sb_note_pending", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          note_t e;
          e = exp_q.pop_front();
          check("sb_addr", cur_addr, e.addr);
          check("sb_step", step_out, e.step);
          check("sb_gate", gate, e.gate);
        end
      end
      if (done) begin
        done_tick <= tick_cnt;
        done_cnt  <= done_cnt + 1;
      end
      if (tick) tick_cnt <= tick_cnt + 1;
      if (tick && gate) gate_tick_cnt <= gate_tick_cnt + 1;
    end
  end

  task automatic push_note(input int addr, input logic [15:0] step);
    note_t n;
    n.addr = ADDR_W'(addr);
    n.step = step;
    n.gate = (step != 16'h0);
    exp_q.push_back(n);
  endtask

  // Tasks below start and end 1 time unit after a rising edge.
  task automatic write_entry(input int addr, input logic [15:0] step, input logic [7:0] dur);
    seq_wr_en   = 1'b1;
    seq_wr_addr = ADDR_W'(addr);
    seq_wr_data = {step, dur};
    @(posedge clk);
    #1 seq_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin : stimulus
    bit seen;
    int g0, d0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step_out", step_out, 16'h0);
    check("rst_gate", gate, 1'b0);
    check("rst_phase_clr", phase_clr, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cur_addr", cur_addr, 6'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    resync();

    // 1: note, rest, end marker
    write_entry(0, 16'h0100, 8'd2);
    write_entry(1, 16'h0000, 8'd3);
    write_entry(2, 16'h1234, 8'd0);
    push_note(0, 16'h0100);
    push_note(1, 16'h0000);
    g0 = gate_tick_cnt;
    d0 = done_cnt;
    pulse_start();
    wait_for_done(600, seen);
    check("t1_done_seen", seen, 1'b1);
    check("t1_busy_in_fin", busy, 1'b1);
    check("t1_step_zero_in_fin", step_out, 16'h0);
    @(negedge clk);
    check("t1_busy_after_done", busy, 1'b0);
    check("t1_done_single_cycle", done, 1'b0);
    check("t1_gate_ticks", gate_tick_cnt - g0, 32'd8);
    check("t1_done_count", done_cnt - d0, 32'd1);
    check("t1_note0_plus_gap_ticks", last_clr_tick - prev_clr_tick, 32'd12);
    check("t1_rest_plus_gap_ticks", done_tick - last_clr_tick, 32'd16);
    resync();

    // 2: latency, same-address write during FETCH, stop(+start) mid-PLAY
    push_note(0, 16'h0100);
    d0 = done_cnt;
    pulse_start();
    seq_wr_en   = 1'b1;
    seq_wr_addr = '0;
    seq_wr_data = {16'hBEEF, 8'd5};
    @(negedge clk);
    check("t2_busy_in_fetch", busy, 1'b1);
    check("t2_clr_n1", phase_clr, 1'b0);
    @(posedge clk);
    #1 seq_wr_en = 1'b0;
    @(negedge clk);
    check("t2_clr_n2", phase_clr, 1'b0);
    @(negedge clk);
    check("t2_clr_n3", phase_clr, 1'b1);
    check("t2_step_n3", step_out, 16'h0100);
    check("t2_gate_n3", gate, 1'b1);
    repeat (6) @(posedge clk);
    #1 check("t2_gate_mid_play", gate, 1'b1);
    stop  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t2_stop_gate", gate, 1'b0);
    check("t2_stop_step", step_out, 16'h0);
    check("t2_stop_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("t2_stop_stays_idle", busy, 1'b0);
    check("t2_stop_no_done", done_cnt - d0, 32'd0);
    resync();
    stop  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t2_idle_stop_wins", busy, 1'b0);
    resync();

    // 3: looping two-note sequence, then release the loop
    write_entry(0, 16'h0200, 8'd1);
    write_entry(1, 16'h0300, 8'd1);
    write_entry(2, 16'h0000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      push_note(0, 16'h0200);
      push_note(1, 16'h0300);
    end
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check("t3_loop_notes_drained", exp_q.size(), 32'd0);
    check("t3_no_done_while_looping", done_cnt - d0, 32'd0);
    check("t3_busy_while_looping", busy, 1'b1);
    loop_en = 1'b0;
    wait_for_done(200, seen);
    check("t3_done_after_loop_off", seen, 1'b1);
    check("t3_addr_at_end_marker", cur_addr, 6'd2);
    resync();

    // 4: empty sequence with loop_en must finish
    write_entry(0, 16'h1111, 8'd0);
    loop_en = 1'b1;
    pulse_start();
    @(negedge clk);
    check("t4_done_n1", done, 1'b0);
    @(negedge clk);
    check("t4_done_n2", done, 1'b0);
    @(negedge clk);
    check("t4_done_n3", done, 1'b1);
    check("t4_gate_n3", gate, 1'b0);
    @(negedge clk);
    check("t4_idle_n4", busy, 1'b0);
    loop_en = 1'b0;
    resync();

    // 6: full table of one-unit notes, address runs off the end
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      write_entry(i, 16'(i + 1), 8'd1);
      push_note(i, 16'(i + 1));
    end
    g0 = gate_tick_cnt;
    pulse_start();
    wait_for_done(4000, seen);
    check("t6_done_seen", seen, 1'b1);
    check("t6_addr_last", cur_addr, 6'd63);
    @(negedge clk);
    check("t6_gate_ticks", gate_tick_cnt - g0, 32'(SEQ_DEPTH * TICK_DIV));
    check("t6_all_notes_played", exp_q.size(), 32'd0);
    resync();

    // 7: asynchronous reset mid-note, RAM contents survive
    push_note(0, 16'h0001);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = gate;
    end
    check("t7_gate_before_reset", gate, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_rst_step_out", step_out, 16'h0);
    check("t7_rst_gate", gate, 1'b0);
    check("t7_rst_phase_clr", phase_clr, 1'b0);
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_done", done, 1'b0);
    check("t7_rst_cur_addr", cur_addr, 6'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    resync();
    push_note(0, 16'h0001);
    pulse_start();
    repeat (6) @(posedge clk);
    #1 check("t7_ram_retained_played", exp_q.size(), 32'd0);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("t7_final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
